// File: rtl/laser_search_ctrl.sv
// laser_search_ctrl: sequencer for the LASER two-circle coverage search.
// It loads the point RAM, then alternates full 256-candidate raster scans for
// circle 1 (even passes) and circle 2 (odd passes) through an external req/ack
// coverage evaluator. It keeps the best union count seen so far and publishes
// both centres with a one-cycle DONE strobe.
module laser_search_ctrl #(
    parameter int NPTS     = 40,
    parameter int MAX_PASS = 6
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       pt_we,
    output logic [5:0] pt_addr,
    output logic       ev_req,
    output logic [3:0] ev_cx,
    output logic [3:0] ev_cy,
    output logic [3:0] ev_fx,
    output logic [3:0] ev_fy,
    input  logic       ev_ack,
    input  logic [5:0] ev_cnt,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic       DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_COMMIT,
        S_OUT
    } state_t;

    state_t     state_reg, state_next;

    logic [5:0] load_cnt_reg;
    logic [3:0] cand_x_reg, cand_y_reg;
    logic       req_reg;
    logic [5:0] run_best_reg;
    logic [3:0] run_x_reg, run_y_reg;
    logic [5:0] best_cnt_reg;
    logic [3:0] pass_reg;
    logic [3:0] c1x_reg, c1y_reg, c2x_reg, c2y_reg;

    // Derived control terms shared by next-state and datapath logic
    logic [3:0] pass_inc;
    logic       improved;
    logic       terminate;
    logic       accept;
    logic       last_cand;
    logic       enter_load;
    logic       enter_scan;
    logic [3:0] scan_pass;
    logic [5:0] scan_best;

    assign pass_inc   = pass_reg + 4'd1;
    assign improved   = run_best_reg > best_cnt_reg;
    assign terminate  = ((pass_inc >= 4'd2) && !improved) || (pass_inc == 4'(MAX_PASS));
    // An ack only counts while a request is outstanding
    assign accept     = (state_reg == S_SCAN) && req_reg && ev_ack;
    assign last_cand  = (cand_x_reg == 4'd15) && (cand_y_reg == 4'd15);
    assign enter_load = (state_next == S_LOAD) && (state_reg != S_LOAD);
    assign enter_scan = (state_next == S_SCAN) && (state_reg != S_SCAN);
    // Values a new pass starts from; coming out of COMMIT they are the ones being committed now
    assign scan_pass  = (state_reg == S_COMMIT) ? pass_inc : pass_reg;
    assign scan_best  = (state_reg == S_COMMIT) ? run_best_reg : best_cnt_reg;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   state_next = S_LOAD;
            S_LOAD:   if (load_cnt_reg == 6'(NPTS - 1)) state_next = S_SCAN;
            S_SCAN:   if (accept && last_cand) state_next = S_COMMIT;
            S_COMMIT: state_next = terminate ? S_OUT : S_SCAN;
            S_OUT:    state_next = S_LOAD;
            default:  state_next = S_IDLE;
        endcase
    end

    // Datapath: load counter, candidate raster, handshake, running best and committed centres
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            load_cnt_reg <= '0;
            cand_x_reg   <= '0;
            cand_y_reg   <= '0;
            req_reg      <= 1'b0;
            run_best_reg <= '0;
            run_x_reg    <= '0;
            run_y_reg    <= '0;
            best_cnt_reg <= '0;
            pass_reg     <= '0;
            c1x_reg      <= '0;
            c1y_reg      <= '0;
            c2x_reg      <= '0;
            c2y_reg      <= '0;
        end else begin
            load_cnt_reg <= (state_reg == S_LOAD) ? load_cnt_reg + 6'd1 : 6'd0;

            if (enter_load) begin
                c1x_reg      <= '0;
                c1y_reg      <= '0;
                c2x_reg      <= '0;
                c2y_reg      <= '0;
                best_cnt_reg <= '0;
                pass_reg     <= '0;
            end

            if (enter_scan) begin
                req_reg      <= 1'b1;
                cand_x_reg   <= '0;
                cand_y_reg   <= '0;
                run_best_reg <= scan_best;
                run_x_reg    <= scan_pass[0] ? c2x_reg : c1x_reg;
                run_y_reg    <= scan_pass[0] ? c2y_reg : c1y_reg;
            end else if (state_reg == S_SCAN) begin
                if (accept) begin
                    // Drop the request for one cycle and step to the next raster position
                    req_reg    <= 1'b0;
                    cand_x_reg <= cand_x_reg + 4'd1;
                    if (cand_x_reg == 4'd15) begin
                        cand_y_reg <= cand_y_reg + 4'd1;
                    end
                    // Strict improvement only, so ties keep the earlier position
                    if (ev_cnt > run_best_reg) begin
                        run_best_reg <= ev_cnt;
                        run_x_reg    <= cand_x_reg;
                        run_y_reg    <= cand_y_reg;
                    end
                end else if (!req_reg) begin
                    req_reg <= 1'b1;
                end
            end

            if (state_reg == S_COMMIT) begin
                if (pass_reg[0]) begin
                    c2x_reg <= run_x_reg;
                    c2y_reg <= run_y_reg;
                end else begin
                    c1x_reg <= run_x_reg;
                    c1y_reg <= run_y_reg;
                end
                best_cnt_reg <= run_best_reg;
                pass_reg     <= pass_inc;
            end
        end
    end

    // Output decode
    always_comb begin
        pt_we   = (state_reg == S_LOAD);
        pt_addr = (state_reg == S_LOAD) ? load_cnt_reg : 6'd0;
        DONE    = (state_reg == S_OUT);
        ev_req  = req_reg;
        ev_cx   = cand_x_reg;
        ev_cy   = cand_y_reg;
        ev_fx   = pass_reg[0] ? c1x_reg : c2x_reg;
        ev_fy   = pass_reg[0] ? c1y_reg : c2y_reg;
        C1X     = c1x_reg;
        C1Y     = c1y_reg;
        C2X     = c2x_reg;
        C2Y     = c2y_reg;
    end

endmodule

// File: tb/tb_laser_search_ctrl.sv
// tb_laser_search_ctrl: randomized-latency evaluator plus a behavioural search model.
// A second instance with MAX_PASS=2 runs alongside on the two-cluster image.
module tb_laser_search_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       pt_we, ev_req, ev_ack, DONE;
    logic [5:0] pt_addr, ev_cnt;
    logic [3:0] ev_cx, ev_cy, ev_fx, ev_fy, C1X, C1Y, C2X, C2Y;

    logic       rst2;
    logic       pt_we2, ev_req2, ev_ack2, done2;
    logic [5:0] pt_addr2, ev_cnt2;
    logic [3:0] ev_cx2, ev_cy2, ev_fx2, ev_fy2, c1x2, c1y2, c2x2, c2y2;

    always #5 CLK = ~CLK;

    laser_search_ctrl #(.NPTS(40), .MAX_PASS(6)) dut (
        .CLK(CLK), .RST(RST), .pt_we(pt_we), .pt_addr(pt_addr), .ev_req(ev_req),
        .ev_cx(ev_cx), .ev_cy(ev_cy), .ev_fx(ev_fx), .ev_fy(ev_fy),
        .ev_ack(ev_ack), .ev_cnt(ev_cnt),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE)
    );

    laser_search_ctrl #(.NPTS(40), .MAX_PASS(2)) dut2 (
        .CLK(CLK), .RST(rst2), .pt_we(pt_we2), .pt_addr(pt_addr2), .ev_req(ev_req2),
        .ev_cx(ev_cx2), .ev_cy(ev_cy2), .ev_fx(ev_fx2), .ev_fy(ev_fy2),
        .ev_ack(ev_ack2), .ev_cnt(ev_cnt2),
        .C1X(c1x2), .C1Y(c1y2), .C2X(c2x2), .C2Y(c2y2), .DONE(done2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Point sets: set 0 feeds the main instance, set 1 is the fixed two-cluster image
    int px[2][40];
    int py[2][40];

    // Union coverage: points within radius 4 of either centre
    function automatic int ucnt(input int s, input int cx, input int cy, input int fx, input int fy);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            int ax = px[s][i] - cx, ay = py[s][i] - cy;
            int bx = px[s][i] - fx, by = py[s][i] - fy;
            if ((ax * ax + ay * ay <= 16) || (bx * bx + by * by <= 16)) n++;
        end
        return n;
    endfunction

    // Alternating exhaustive search over all 256 centres, written from the search rules
    task automatic model(input int s, input int maxp, output int o1x, output int o1y,
                         output int o2x, output int o2y, output int np);
        int cx[2], cy[2];
        int best, rb, rx, ry, t, p, c;
        bit imp;
        cx = '{0, 0};
        cy = '{0, 0};
        best = 0;
        p = 0;
        while (1) begin
            t = p % 2;
            rb = best;
            rx = cx[t];
            ry = cy[t];
            for (int y = 0; y < 16; y++) begin
                for (int x = 0; x < 16; x++) begin
                    c = ucnt(s, x, y, cx[1-t], cy[1-t]);
                    if (c > rb) begin
                        rb = c;
                        rx = x;
                        ry = y;
                    end
                end
            end
            cx[t] = rx;
            cy[t] = ry;
            imp = rb > best;
            best = rb;
            p++;
            if ((p >= 2 && !imp) || p == maxp) break;
        end
        o1x = cx[0]; o1y = cy[0]; o2x = cx[1]; o2y = cy[1]; np = p;
    endtask

    task automatic set_pts(input int s, input int mode);
        for (int i = 0; i < 40; i++) begin
            if (mode == 0) begin
                px[s][i] = 3; py[s][i] = 3;
            end else if (mode == 1) begin
                px[s][i] = (i < 20) ? 3 : 12;
                py[s][i] = (i < 20) ? 3 : 12;
            end else begin
                px[s][i] = $urandom_range(0, 15);
                py[s][i] = $urandom_range(0, 15);
            end
        end
    endtask

    // Main evaluator: random latency, stray acks injected only while req is low
    logic       ack_reg = 1'b0;
    logic       stray_reg = 1'b0;
    logic [5:0] cnt_reg = '0;
    int         wcnt = 0;
    int         max_lat = 0;
    bit         stray_en = 1'b0;

    always @(posedge CLK) begin
        stray_reg <= stray_en && ($urandom_range(0, 3) == 0);
        if (ack_reg) begin
            ack_reg <= 1'b0;
        end else if (ev_req) begin
            if (wcnt == 0) begin
                ack_reg <= 1'b1;
                cnt_reg <= 6'(ucnt(0, int'(ev_cx), int'(ev_cy), int'(ev_fx), int'(ev_fy)));
                wcnt    <= $urandom_range(0, max_lat);
            end else begin
                wcnt <= wcnt - 1;
            end
        end
    end

    assign ev_ack = ack_reg | (stray_reg & ~ev_req);
    assign ev_cnt = ack_reg ? cnt_reg : 6'd63;

    // Second evaluator: fixed one-cycle ack
    logic       ack2_reg = 1'b0;
    logic [5:0] cnt2_reg = '0;

    always @(posedge CLK) begin
        ack2_reg <= ev_req2 && !ack2_reg;
        cnt2_reg <= 6'(ucnt(1, int'(ev_cx2), int'(ev_cy2), int'(ev_fx2), int'(ev_fy2)));
    end

    assign ev_ack2 = ack2_reg;
    assign ev_cnt2 = cnt2_reg;

    // Expected per-image results, written by the main sequence
    int e_c1x, e_c1y, e_c2x, e_c2y, e_passes;
    int done_cnt = 0;
    int acks = 0;
    int we_cnt = 0;
    logic [7:0] exp_idx = '0;
    logic       p_req = 1'b0, p_ack = 1'b0, p_done = 1'b0;
    logic [15:0] p_coords = '0;

    // Protocol monitor and per-image result check for the main instance
    always @(negedge CLK) begin
        if (RST) begin
            exp_idx <= '0;
            acks    <= 0;
            we_cnt  <= 0;
            p_req   <= 1'b0;
            p_ack   <= 1'b0;
            p_done  <= 1'b0;
        end else begin
            if (p_req && !p_ack) begin
                check("req_hold", 32'(ev_req), 32'd1);
                check("coord_hold", 32'({ev_cx, ev_cy, ev_fx, ev_fy}), 32'(p_coords));
            end
            if (pt_we) begin
                check("pt_addr", 32'(pt_addr), 32'(we_cnt));
                we_cnt <= we_cnt + 1;
            end
            if (ev_req && ev_ack) begin
                check("cand_order", 32'({ev_cy, ev_cx}), 32'(exp_idx));
                exp_idx <= exp_idx + 8'd1;
                acks    <= acks + 1;
            end
            if (p_done) begin
                check("after_done_ctl", 32'({DONE, pt_we, pt_addr}), 32'({1'b0, 1'b1, 6'd0}));
                check("after_done_c", 32'({C1X, C1Y, C2X, C2Y}), 32'd0);
            end
            if (DONE) begin
                check("c1", 32'({C1X, C1Y}), 32'((e_c1x << 4) | e_c1y));
                check("c2", 32'({C2X, C2Y}), 32'((e_c2x << 4) | e_c2y));
                check("acks", 32'(acks), 32'(256 * e_passes));
                check("load_len", 32'(we_cnt), 32'd40);
                $display("image %0d: C1=(%0d,%0d) C2=(%0d,%0d) acks=%0d", done_cnt + 1,
                         C1X, C1Y, C2X, C2Y, acks);
                done_cnt <= done_cnt + 1;
                acks     <= 0;
                we_cnt   <= 0;
                exp_idx  <= '0;
            end
            p_req    <= ev_req;
            p_ack    <= ev_ack;
            p_done   <= DONE;
            p_coords <= {ev_cx, ev_cy, ev_fx, ev_fy};
        end
    end

    // MAX_PASS=2 instance: first DONE must come after exactly two passes
    int  acks2 = 0;
    bit  done2_seen = 1'b0;

    always @(negedge CLK) begin
        if (!rst2 && !done2_seen) begin
            if (ev_req2 && ev_ack2) acks2 <= acks2 + 1;
            if (done2) begin
                check("mp2_c1", 32'({c1x2, c1y2}), 32'h10);
                check("mp2_c2", 32'({c2x2, c2y2}), 32'hC8);
                check("mp2_acks", 32'(acks2), 32'd512);
                $display("maxpass2 image: C1=(%0d,%0d) C2=(%0d,%0d) acks=%0d",
                         c1x2, c1y2, c2x2, c2y2, acks2);
                done2_seen <= 1'b1;
            end
        end
    end

    task automatic wait_done(input int k, input int budget);
        int n = 0;
        while (done_cnt < k && n < budget) begin
            @(posedge CLK);
            n++;
        end
        check("done_timeout", 32'(done_cnt >= k), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 32'({pt_we, pt_addr, ev_req, DONE}), 32'd0);
        check({tag, "_ev"}, 32'({ev_cx, ev_cy, ev_fx, ev_fy}), 32'd0);
        check({tag, "_c"}, 32'({C1X, C1Y, C2X, C2Y}), 32'd0);
    endtask

    initial begin
        int k;
        RST  = 1'b1;
        rst2 = 1'b1;
        set_pts(0, 0);
        set_pts(1, 1);
        // Single cluster at (3,3), one-cycle ack
        e_c1x = 1; e_c1y = 0; e_c2x = 0; e_c2y = 0; e_passes = 2;
        repeat (3) @(negedge CLK);
        check_zero("reset");
        RST  = 1'b0;
        rst2 = 1'b0;
        @(negedge CLK);
        check("idle_to_load", 32'({pt_we, pt_addr}), 32'({1'b1, 6'd0}));
        wait_done(1, 5000);

        // Two clusters, random latency and stray acks
        stray_en = 1'b1;
        max_lat  = 7;
        set_pts(0, 1);
        e_c1x = 1; e_c1y = 0; e_c2x = 12; e_c2y = 8; e_passes = 3;
        wait_done(2, 20000);

        // Same image again, interrupted by reset during pass 1, then rerun from scratch
        k = 0;
        while (acks < 286 && k < 20000) begin
            @(negedge CLK);
            k++;
        end
        check("reach_pass1", 32'(acks >= 286), 32'd1);
        RST = 1'b1;
        #1;
        check_zero("mid_reset");
        repeat (3) @(negedge CLK);
        check("no_done_on_abort", 32'(done_cnt), 32'd2);
        RST = 1'b0;
        wait_done(3, 20000);

        // Random point sets checked against the search model
        max_lat = 3;
        for (int r = 0; r < 3; r++) begin
            set_pts(0, 2);
            model(0, 6, e_c1x, e_c1y, e_c2x, e_c2y, e_passes);
            wait_done(4 + r, 25000);
        end

        k = 0;
        while (!done2_seen && k < 5000) begin
            @(posedge CLK);
            k++;
        end
        check("mp2_done", 32'(done2_seen), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
